// File: rtl/seq_encoder_8to3_pkg.sv
// -----------------------------------------------------------------------------
// seq_encoder_8to3_pkg
//   Shared definitions for the sequential 8-to-3 encoder:
//     - default geometry (WIDTH_DEF request lines, IDX_W_DEF index bits)
//     - FSM state encoding (IDLE, SCAN, NONE)
//     - small helpers used by the encoder and its find-first-set block
//   Configuration: none of the items here depend on ENC_HIGH_FIRST_EN.
// -----------------------------------------------------------------------------
package seq_encoder_8to3_pkg;

    // Default geometry: WIDTH must always equal 2**IDX_W.
    localparam int WIDTH_DEF = 8;
    localparam int IDX_W_DEF = 3;

    // FSM state encoding. Kept as plain constants so the encoding is fixed
    // and visible to any tool that inspects the state register.
    localparam int           STATE_W  = 2;
    localparam logic [1:0]   ST_IDLE  = 2'd0;
    localparam logic [1:0]   ST_SCAN  = 2'd1;
    localparam logic [1:0]   ST_NONE  = 2'd2;

    // True for every state that presents a beat on the output port.
    function automatic logic state_has_beat(input logic [STATE_W-1:0] st);
        return (st == ST_SCAN) || (st == ST_NONE);
    endfunction

endpackage : seq_encoder_8to3_pkg

// File: rtl/seq_encoder_8to3_ffs.sv
// -----------------------------------------------------------------------------
// ffs_8to3
//   Combinational find-first-set over a request vector.
//   Default build: reports the LOWEST set bit.
//   With ENC_HIGH_FIRST_EN defined: reports the HIGHEST set bit.
//
//   Parameters
//     WIDTH  number of request lines (must equal 2**IDX_W)
//     IDX_W  width of the reported index
//   Ports
//     vec     input  [WIDTH-1:0]  vector to scan
//     idx     output [IDX_W-1:0]  index of the selected set bit (0 if none)
//     found   output              at least one bit of vec is set
//     single  output              exactly one bit of vec is set
// -----------------------------------------------------------------------------
module ffs_8to3
    import seq_encoder_8to3_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             found,
    output logic             single
);

    logic [WIDTH-1:0] vec_minus_one;

    assign vec_minus_one = vec - WIDTH'(1);

    // Priority scan: the iteration that runs last wins, so the loop direction
    // selects which end of the vector has priority.
    always_comb begin
        idx = '0;
`ifdef ENC_HIGH_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
`endif
    end

    assign found  = |vec;
    // Clearing the lowest set bit leaves zero only for a one-hot vector.
    assign single = found && ((vec & vec_minus_one) == '0);

endmodule : ffs_8to3

// File: rtl/seq_encoder_8to3.sv
// -----------------------------------------------------------------------------
// seq_encoder_8to3
//   Sequential 8-to-3 encoder: captures a request vector and emits one encoded
//   beat per set bit through a valid/ready handshake (the inverse of a 3-to-8
//   decoder). An all-zero vector produces a single beat flagged with none=1.
//
//   Configuration macro
//     ENC_HIGH_FIRST_EN  defined   -> highest set bit first (descending)
//                        undefined -> lowest set bit first (ascending)
//
//   Parameters
//     WIDTH  number of request lines (default 8, must equal 2**IDX_W)
//     IDX_W  encoded index width     (default 3, needs IDX_W >= 2)
//   Ports
//     clk        input   single clock, rising edge
//     rst_n      input   synchronous active-low reset
//     e          input   request vector valid
//     d          input   request vector, d[i] asserts line i
//     in_ready   output  a new vector can be captured
//     out_valid  output  an encoded beat is on a/b/c
//     out_ready  input   downstream accepts the beat
//     a, b, c    output  encoded index {a,b,c}, a is the MSB
//     last       output  current beat is the final beat of the vector
//     none       output  the captured vector was all-zero
// -----------------------------------------------------------------------------
module seq_encoder_8to3
    import seq_encoder_8to3_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             e,
    input  logic [WIDTH-1:0] d,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             last,
    output logic             none
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [STATE_W-1:0] state_reg,     state_next;
    logic [WIDTH-1:0]   pend_reg,      pend_next;
    logic [IDX_W-1:0]   idx_reg,       idx_next;
    logic               last_reg,      last_next;
    logic               none_reg,      none_next;
    logic               in_ready_reg,  in_ready_next;
    logic               out_valid_reg, out_valid_next;

    // Find-first-set result for the pending vector of the NEXT cycle.
    logic [IDX_W-1:0]   ffs_idx;
    logic               ffs_found;
    logic               ffs_single;

    // One-hot mask of the bit currently being presented.
    logic [WIDTH-1:0]   clr_mask;

    logic               capture;
    logic               handshake;

    assign capture   = in_ready_reg && e;
    assign handshake = out_valid_reg && out_ready;

    // ------------------------------------------------------------------
    // Decode the presented index back into a clear mask.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_clr
            assign clr_mask[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // The FFS looks at pend_next rather than pend_reg. That lets every
    // output be a plain register loaded from the FFS result, while a
    // single FFS instance serves both the capture path (scan of d) and
    // the handshake path (scan of pend with the current bit cleared).
    // ------------------------------------------------------------------
    ffs_8to3 #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_ffs (
        .vec    (pend_next),
        .idx    (ffs_idx),
        .found  (ffs_found),
        .single (ffs_single)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg;

        case (state_reg)
            ST_IDLE: begin
                if (capture) begin
                    pend_next  = d;
                    state_next = (d != '0) ? ST_SCAN : ST_NONE;
                end
            end

            ST_SCAN: begin
                if (handshake) begin
                    pend_next = pend_reg & ~clr_mask;
                    if (last_reg) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_NONE: begin
                if (handshake) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle.
                state_next = ST_IDLE;
                pend_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs derived from the next state. While stalled the
    // pending vector does not change, so the FFS result and therefore
    // every output hold their values.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready_next  = (state_next == ST_IDLE);
        out_valid_next = state_has_beat(state_next);
        none_next      = (state_next == ST_NONE);
        idx_next       = '0;
        last_next      = 1'b0;

        if (state_next == ST_SCAN) begin
            idx_next  = ffs_idx;
            // ffs_found is implied by SCAN; keep it in the term so an empty
            // pending vector can never flag a final beat.
            last_next = ffs_found && ffs_single;
        end else if (state_next == ST_NONE) begin
            last_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pend_reg      <= '0;
            idx_reg       <= '0;
            last_reg      <= 1'b0;
            none_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pend_reg      <= pend_next;
            idx_reg       <= idx_next;
            last_reg      <= last_next;
            none_reg      <= none_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping: {a,b,c} = {MSB, next bit, LSB} of the index.
    // ------------------------------------------------------------------
    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign a         = idx_reg[IDX_W-1];
    assign b         = idx_reg[IDX_W-2];
    assign c         = idx_reg[0];
    assign last      = last_reg;
    assign none      = none_reg;

endmodule : seq_encoder_8to3

// File: tb/tb_seq_encoder_8to3.sv
// -----------------------------------------------------------------------------
// tb_seq_encoder_8to3
//   Directed stimulus for seq_encoder_8to3 with a queue-based scoreboard.
//   The stimulus process pushes the hand-computed beats of each vector into
//   exp_q; a monitor pops one entry per accepted beat and compares it.
//   Expected order follows ENC_HIGH_FIRST_EN when the bench is built with it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_encoder_8to3;

    logic       clk;
    logic       rst_n;
    logic       e;
    logic [7:0] d;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic       a;
    logic       b;
    logic       c;
    logic       last;
    logic       none;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Expected beat: {idx[2:0], last, none}
    logic [4:0] exp_q[$];

    seq_encoder_8to3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .e         (e),
        .d         (d),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .last      (last),
        .none      (none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        check_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            pass_cnt++;
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic push(input int idx, input bit lst, input bit nn);
        logic [2:0] i3;
        i3 = 3'(idx);
        exp_q.push_back({i3, lst, nn});
    endtask

    // ------------------------------------------------------------------
    // Monitor: samples on the falling edge, i.e. the values the DUT will
    // present at the next rising edge.
    // ------------------------------------------------------------------
    initial begin
        logic       stalled;
        logic [4:0] held;
        logic [4:0] exp_beat;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled && out_valid)
                    check("stall_hold", {3'b0, a, b, c, last, none}, {3'b0, held});
                stalled = out_valid && !out_ready;
                held    = {a, b, c, last, none};
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_cnt++;
                        $display("FAIL unexpected_beat: got %b, expected no beat", {a, b, c, last, none});
                    end else begin
                        exp_beat = exp_q.pop_front();
                        check("beat", {3'b0, a, b, c, last, none}, {3'b0, exp_beat});
                    end
                end
            end
        end
    end

    // Capture one vector; checks one-cycle latency to out_valid.
    task automatic capture(input logic [7:0] vec);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check_cnt++;
            $display("FAIL capture_wait: in_ready stuck at 0, expected 1");
        end
        e = 1'b1;
        d = vec;
        @(posedge clk); #1;
        e = 1'b0;
        check("latency", {6'b0, out_valid, in_ready}, 8'b10);
    endtask

    // Run handshakes until every expected beat is consumed, then check the
    // block is back in IDLE on the following cycle.
    task automatic drain(input bit toggle);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (n < 200) begin
            @(posedge clk); #1;
            n++;
            if (exp_q.size() == 0) break;
            if (toggle) out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        if (exp_q.size() != 0) begin
            check_cnt++;
            $display("FAIL drain_timeout: %0d beats missing, expected 0", exp_q.size());
            exp_q.delete();
        end
        check("back_idle", {6'b0, in_ready, out_valid}, 8'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        e         = 1'b1;   // must be ignored during reset
        d         = 8'hFF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {1'b0, in_ready, out_valid, a, b, c, last, none}, 8'b0100_0000);
        rst_n = 1'b1;
        e     = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", {1'b0, in_ready, out_valid, a, b, c, last, none}, 8'b0100_0000);

        // Two set bits: 2 then 5 (descending build: 5 then 2)
`ifdef ENC_HIGH_FIRST_EN
        push(5, 0, 0); push(2, 1, 0);
`else
        push(2, 0, 0); push(5, 1, 0);
`endif
        capture(8'b0010_0100);
        drain(1'b0);

        // All-zero vector: single none beat
        push(0, 1, 1);
        capture(8'h00);
        drain(1'b0);

        // Full vector with out_ready toggling
`ifdef ENC_HIGH_FIRST_EN
        for (int i = 7; i >= 0; i--) push(i, (i == 0), 0);
`else
        for (int i = 0; i < 8; i++) push(i, (i == 7), 0);
`endif
        capture(8'hFF);
        drain(1'b1);

        // Vector offered while busy must be ignored
`ifdef ENC_HIGH_FIRST_EN
        push(7, 0, 0); push(0, 1, 0);
`else
        push(0, 0, 0); push(7, 1, 0);
`endif
        out_ready = 1'b0;
        capture(8'h81);
        e = 1'b1;
        d = 8'h02;
        repeat (3) @(posedge clk);
        #1;
        e = 1'b0;
        check("busy_in_ready", {7'b0, in_ready}, 8'b0);
        drain(1'b0);

        // Reset after the first beat discards the rest
`ifdef ENC_HIGH_FIRST_EN
        push(7, 0, 0);
`else
        push(4, 0, 0);
`endif
        capture(8'hF0);
        @(posedge clk); #1;     // first beat accepted at this edge
        rst_n = 1'b0;
        e     = 1'b1;
        d     = 8'h0F;
        @(posedge clk); #1;
        check("mid_reset_state", {1'b0, in_ready, out_valid, a, b, c, last, none}, 8'b0100_0000);
        check("mid_reset_beats_left", 8'(exp_q.size()), 8'd0);
        rst_n = 1'b1;
        e     = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("after_reset_quiet", {6'b0, in_ready, out_valid}, 8'b10);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule : tb_seq_encoder_8to3

// File: doc/seq_encoder_8to3.md
SEQ_ENCODER_8TO3 -- requirements
Module: seq_encoder_8to3

Interface
REQ-001 Parameter WIDTH, default 8, number of request lines; SHALL equal 2**IDX_W.
REQ-002 Parameter IDX_W, default 3, encoded index width, mapped to a (MSB), b, c (LSB).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 e  input  1  request-vector valid (enable).
REQ-006 d  input  WIDTH  request vector; d[i] asserts line i.
REQ-007 in_ready  output  1  block can capture a new vector.
REQ-008 out_valid  output  1  encoded beat present on a/b/c.
REQ-009 out_ready  input  1  downstream accepts the beat.
REQ-010 a, b, c  output  1 each  encoded index of the current line, {a,b,c}.
REQ-011 last  output  1  current beat is the final beat of the vector.
REQ-012 none  output  1  the captured vector was all-zero.

Function
REQ-013 The block SHALL serialise every set bit of a captured vector into one encoded beat per handshake: the inverse of the 3-to-8 decoder.
REQ-014 The FSM SHALL have three states:
- IDLE: in_ready=1, out_valid=0.
- SCAN: out_valid=1.
- NONE: out_valid=1, none=1.
REQ-015 IDLE, capture:
- Capture on the rising edge where e=1 and in_ready=1.
- Load d into the pending register pend.
- Next state is SCAN if d!=0, otherwise NONE.
- in_ready SHALL be 0 from the next cycle.
REQ-016 When e=1 with in_ready=0, the block SHALL ignore d and e.
REQ-017 Latency: out_valid SHALL assert in the cycle after capture. All outputs are registered.
REQ-018 SCAN, index: {a,b,c} SHALL be the index of the lowest set bit of pend.
REQ-019 SCAN, last: last=1 when pend has exactly one bit set.
REQ-020 SCAN, handshake: a beat completes on the edge where out_valid=1 and out_ready=1.
- The encoded bit is cleared from pend.
- The next beat presents in the following cycle, with no bubble.
REQ-021 SCAN, stall: while out_valid=1 and out_ready=0, a, b, c, last and none SHALL hold stable.
REQ-022 Return to IDLE: on the handshake of a beat with last=1, the state SHALL become IDLE and in_ready=1 in the next cycle. A new capture is possible no earlier than that cycle.
REQ-023 NONE: emits a single beat with {a,b,c}=0, last=1, none=1, then returns to IDLE on its handshake.
REQ-024 none SHALL be 0 in SCAN and IDLE.
REQ-025 A full vector of WIDTH set bits SHALL produce exactly WIDTH beats, in ascending index order.

Reset
REQ-026 While rst_n=0 at a rising edge, the block SHALL load:
- state IDLE, pend 0;
- in_ready=1, out_valid=0;
- a=b=c=0, last=0, none=0.
REQ-027 A reset mid-vector SHALL discard the pending bits, with no further beats emitted.
REQ-028 Any e asserted in the reset cycle SHALL be ignored.

Configuration
REQ-029 Macro ENC_HIGH_FIRST_EN selects the scan order.
- Defined: SCAN SHALL encode the highest set bit of pend first (descending order).
- Undefined: lowest set bit first, as in REQ-018.
- All other behaviour is identical in both builds.

Structure
REQ-030 A shared package SHALL hold:
- the FSM state encoding (IDLE, SCAN, NONE);
- constants WIDTH_DEF=8 and IDX_W_DEF=3.
REQ-031 The find-first-set logic SHALL be a combinational sub-module, ffs_8to3: input a vector; outputs the index, a found flag and a single-bit flag. The parent instantiates it once.

Verification
REQ-032 e=1, d=8'b0010_0100, out_ready=1 -> two beats: {a,b,c}=2 with last=0, then 5 with last=1. in_ready=1 on the next cycle.
REQ-033 e=1, d=8'h00 -> one beat: none=1, last=1, {a,b,c}=0. Back to IDLE after the handshake.
REQ-034 d=8'hFF with out_ready toggling 1,0,1,0 -> indices 0..7 in order, outputs held during the 0 cycles, last only on index 7.
REQ-035 Capture d=8'h81, then assert e with d=8'h02 while busy -> only indices 0 and 7 are emitted; the 8'h02 vector is ignored.
REQ-036 Capture d=8'hF0, then drive rst_n=0 after the first beat -> next cycle out_valid=0, in_ready=1, with no remaining beats.
REQ-037 Build with ENC_HIGH_FIRST_EN, d=8'b0010_0100 -> beats 5 then 2, with last on 2.
